// File: rtl/seg7_scan_driver_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver_if
//   Bundles the BCD input strobe and the multiplexed display outputs of
//   seg7_scan_driver.
//
//   bcd         [11:0]  packed BCD word: [11:8] hundreds, [7:4] tens, [3:0] units
//   bcd_valid           one-cycle strobe; bcd is sampled when high
//   seg         [6:0]   segment bus {a,b,c,d,e,f,g}, a = MSB
//   dig         [2:0]   one-hot digit enable, bit0 = units
//   frame_start         one-cycle pulse when the units slot begins
//   bcd_err             sticky flag, a displayed nibble was above 9
//
//   master: the producer of BCD words and consumer of the display pins.
//   slave : the scan driver itself.
// ---------------------------------------------------------------------------
interface seg7_scan_driver_if;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic [6:0]  seg;
  logic [2:0]  dig;
  logic        frame_start;
  logic        bcd_err;

  modport master (
    output bcd, bcd_valid,
    input  seg, dig, frame_start, bcd_err
  );

  modport slave (
    input  bcd, bcd_valid,
    output seg, dig, frame_start, bcd_err
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//   Drives a 3-digit multiplexed 7-segment display from a packed BCD word.
//   A prescaler divides clk into digit slots of REFRESH_DIV cycles; a scan
//   index walks units -> tens -> hundreds. New BCD words are parked in a
//   pending register and copied into the displayed value only at a frame
//   boundary, so a frame never mixes digits of two different words.
//   Each slot starts with GUARD cycles of all digit enables off so the old
//   segment pattern cannot ghost onto the next digit.
//
//   Ports:
//     clk      system clock
//     rst      synchronous active-high reset
//     io_disp  seg7_scan_driver_if.slave (bcd, bcd_valid in;
//              seg, dig, frame_start, bcd_err out)
//
//   Outputs are registered from the post-tick (next-state) values so the
//   segment bus, digit enable and frame pulse all switch on the same edge
//   as the scan state. Nothing is lit until the first tick after reset.
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int REFRESH_DIV    = 50000,
  parameter int GUARD          = 2,
  parameter bit BLANK_LZ       = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input logic              clk,
  input logic              rst,
  seg7_scan_driver_if.slave io_disp
);

  localparam int            PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GUARD_W    = PW'(GUARD);
  localparam logic [6:0]    SEG_INV    = {7{SEG_ACTIVE_LOW}};
  localparam logic [2:0]    DIG_INV    = {3{DIG_ACTIVE_LOW}};

  // Active-high glyphs; invalid nibbles render as all segments off.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0:    glyph = 7'b1111110;
      4'd1:    glyph = 7'b0110000;
      4'd2:    glyph = 7'b1101101;
      4'd3:    glyph = 7'b1111001;
      4'd4:    glyph = 7'b0110011;
      4'd5:    glyph = 7'b1011011;
      4'd6:    glyph = 7'b1011111;
      4'd7:    glyph = 7'b1110000;
      4'd8:    glyph = 7'b1111111;
      4'd9:    glyph = 7'b1111011;
      default: glyph = 7'b0000000;
    endcase
  endfunction

  // Scan state
  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [11:0]   r_pending;
  logic [11:0]   r_display;
  logic          r_live;      // set by the first tick; keeps the display dark until then

  // Registered outputs (already in pin polarity)
  logic [6:0]    r_seg;
  logic [2:0]    r_dig;
  logic          r_frame_start;
  logic          r_bcd_err;

  // Next-state and output-decode wires
  logic          w_tick;
  logic          w_boundary;
  logic [PW-1:0] w_presc_nx;
  logic [1:0]    w_idx_nx;
  logic [11:0]   w_display_nx;
  logic          w_live_nx;
  logic [3:0]    w_nib;
  logic [2:0]    w_dig_hot;
  logic          w_blank;
  logic          w_nib_bad;
  logic [6:0]    w_seg_ah;
  logic [2:0]    w_dig_ah;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can
    // leave it unassigned, which would otherwise infer a latch.
    w_tick       = (r_presc == PRESC_LAST);
    w_boundary   = w_tick && (r_idx == 2'd2);
    w_presc_nx   = w_tick ? '0 : r_presc + 1'b1;
    w_idx_nx     = r_idx;
    w_display_nx = r_display;
    w_live_nx    = r_live | w_tick;
    w_nib        = 4'd0;
    w_dig_hot    = 3'b000;
    w_blank      = 1'b1;

    // Index 3 is unreachable, but it falls back to 0 on the next tick.
    if (w_tick)
      w_idx_nx = (r_idx >= 2'd2) ? 2'd0 : r_idx + 2'd1;

    // A strobe on the boundary cycle itself wins over the pending word.
    if (w_boundary)
      w_display_nx = io_disp.bcd_valid ? io_disp.bcd : r_pending;

    case (w_idx_nx)
      2'd0: begin
        w_nib     = w_display_nx[3:0];
        w_dig_hot = 3'b001;
        w_blank   = 1'b0;
      end
      2'd1: begin
        w_nib     = w_display_nx[7:4];
        w_dig_hot = 3'b010;
        w_blank   = BLANK_LZ && (w_display_nx[11:4] == 8'd0);
      end
      2'd2: begin
        w_nib     = w_display_nx[11:8];
        w_dig_hot = 3'b100;
        w_blank   = BLANK_LZ && (w_display_nx[11:8] == 4'd0);
      end
      default: begin
        w_nib     = 4'd0;
        w_dig_hot = 3'b000;
        w_blank   = 1'b1;
      end
    endcase

    w_nib_bad = (w_nib > 4'd9);
    w_seg_ah  = (!w_live_nx || w_blank || w_nib_bad) ? 7'b0000000 : glyph(w_nib);
    // Guard: the new pattern is already on seg while all digits stay off.
    w_dig_ah  = (!w_live_nx || (w_presc_nx < GUARD_W)) ? 3'b000 : w_dig_hot;
  end

  always_ff @(posedge clk) begin
    // NOTE: state and outputs use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      // NOTE: the pending and displayed words are reset too, because the
      // display must read 0 immediately after reset.
      r_presc       <= '0;
      r_idx         <= 2'd0;
      r_pending     <= 12'd0;
      r_display     <= 12'd0;
      r_live        <= 1'b0;
      r_seg         <= SEG_INV;
      r_dig         <= DIG_INV;
      r_frame_start <= 1'b0;
      r_bcd_err     <= 1'b0;
    end else begin
      r_presc   <= w_presc_nx;
      r_idx     <= w_idx_nx;
      r_display <= w_display_nx;
      r_live    <= w_live_nx;
      if (io_disp.bcd_valid)
        r_pending <= io_disp.bcd;

      r_seg         <= w_seg_ah ^ SEG_INV;
      r_dig         <= w_dig_ah ^ DIG_INV;
      r_frame_start <= w_tick && (w_idx_nx == 2'd0);
      if (w_live_nx && w_nib_bad)
        r_bcd_err <= 1'b1;
    end
  end

  assign io_disp.seg         = r_seg;
  assign io_disp.dig         = r_dig;
  assign io_disp.frame_start = r_frame_start;
  assign io_disp.bcd_err     = r_bcd_err;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream stage of the binary-to-BCD converter: consumes the 12-bit packed BCD word (3 digits) and drives a 3-digit multiplexed 7-segment display.
- Shares one segment bus across all digits, with a refresh prescaler, a digit scan counter and a frame-synchronous shadow register so digits never tear.
- Adds leading-zero blanking and an anti-ghosting guard interval.
- Segment encoding is {a,b,c,d,e,f,g} with a as MSB; the active-high glyph for 0 is 1111110.

Parameters:
- REFRESH_DIV, 50000, clock cycles per digit slot (min 4).
- GUARD, 2, cycles at the start of each slot with all digit enables off (must be < REFRESH_DIV).
- BLANK_LZ, 1, 1 = blank leading zeros on digits 2 and 1.
- SEG_ACTIVE_LOW, 0, 1 = invert seg output.
- DIG_ACTIVE_LOW, 0, 1 = invert dig output.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- bcd, input, 12, packed BCD: [11:8] hundreds, [7:4] tens, [3:0] units.
- bcd_valid, input, 1, one-cycle strobe; bcd is sampled when high.
- seg, output, 7, registered segment bus {a..g}.
- dig, output, 3, registered one-hot digit enable; bit0 = units.
- frame_start, output, 1, one-cycle pulse when the digit 0 slot begins.
- bcd_err, output, 1, sticky flag, set when a displayed nibble > 9.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values (after polarity inversion is applied):
  - prescaler = 0, digit index = 0, pending = 0, display = 0.
  - seg = all off, dig = all off, frame_start = 0, bcd_err = 0.
  - rst wins over every other event in the same cycle, including bcd_valid and tick.
- Prescaler:
  - Counts 0 to REFRESH_DIV-1, then wraps to 0.
  - tick is asserted in the cycle the prescaler equals REFRESH_DIV-1.
  - The first tick after reset release occurs REFRESH_DIV cycles after the last rst cycle.
- Digit index:
  - Advances on tick: 0 -> 1 -> 2 -> 0.
  - A frame boundary is a tick with index = 2.
- Capture:
  - When bcd_valid = 1, pending <= bcd.
  - At a frame boundary, display <= (bcd_valid ? bcd : pending). A strobe coinciding with the boundary is therefore displayed in the new frame.
  - A strobe at any other time becomes visible at the next frame boundary.
  - Multiple strobes within one frame: last one wins.
  - Worst-case latency from strobe to visible is 3*REFRESH_DIV+1 cycles.
- Output registration:
  - seg, dig and frame_start are registered one cycle after tick.
  - The index, prescaler and display values used are those after the tick update.
- Guard interval:
  - During the first GUARD cycles of each slot (post-tick prescaler 0..GUARD-1), dig = all off.
  - seg already shows the new digit's pattern during the guard.
  - After the guard, dig is one-hot on the current index.
- Glyphs (active-high):
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011.
  - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011.
- Invalid nibble (10-15): seg = all off, and bcd_err is set while that digit is driven. bcd_err is cleared only by rst.
- Leading-zero blanking (BLANK_LZ = 1):
  - Digit 2 is blanked if display[11:8] = 0.
  - Digit 1 is blanked if display[11:4] = 0.
  - Digit 0 is never blanked.
  - A blanked digit gives seg = all off; dig still follows the normal scan.
- frame_start: high for exactly the one cycle in which the outputs switch to digit 0. It is never asserted in the first cycle after reset.
- Polarity: SEG_ACTIVE_LOW and DIG_ACTIVE_LOW invert the final registered outputs, including their reset values.
- Width rules: prescaler width is clog2(REFRESH_DIV); index is 2 bits; index value 3 is unreachable and, if reached, returns to 0 on the next tick.

Test Plan (REFRESH_DIV = 4, GUARD = 1, BLANK_LZ = 1, active-high, unless noted):
1. Reset hold, then release.
   - Required: seg = 0000000 and dig = 000 throughout reset.
   - Required: first dig = 010 (digit 1) appears 2 cycles after the first tick, i.e. one guard cycle after the outputs register.
   - Required: frame_start first pulses at the slot for index 0, i.e. 3 ticks after reset.
2. Strobe bcd = 0x123 mid-frame.
   - Required: digits show 1/2/3 starting at the next frame_start, not earlier.
   - Required: units slot seg = 1111001, tens slot 1101101, hundreds slot 0110000.
3. Strobe bcd = 0x007 exactly on a frame-boundary cycle.
   - Required: the new frame shows it immediately.
   - Required: hundreds and tens slots give seg = 0000000, units slot 1110000.
   - Required: with bcd = 0x000, only the units slot shows 1111110.
4. Two strobes in one frame, 0x456 then 0x789.
   - Required: only 789 is ever displayed; 456 never appears on seg.
5. bcd = 0x1A3 strobed.
   - Required: tens slot seg = 0000000.
   - Required: bcd_err rises during the tens slot and stays high until rst.
6. Assert rst for 1 cycle mid-slot, with DIG_ACTIVE_LOW = 1.
   - Required: next cycle dig = 111, seg = 0000000, bcd_err = 0, display = 0.
   - Required: the scan restarts exactly as in scenario 1.
